instr_mem_ctrl: RTL and testbench
=================================

Name: instr_mem_ctrl

Overview:
Parametrised instruction memory with a registered fetch port, a runtime program-load port and a post-reset clear sequencer. It replaces the fixed 15-entry, initial-block ROM. It sits between the PC register and the decode stage of the 16-bit core. During bring-up, the test harness or boot logic loads the program through the load port.

Parameters:
DATA_W, 16, instruction word width in bits
ADDR_W, 16, PC width in bits (byte address)
DEPTH, 16, number of instruction words; must be ≥2
NOP_WORD, 16'h0000, value used by clear and returned on faulted fetches

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
pc  in  ADDR_W  byte address of the fetch
fetch_req  in  1  fetch request
fetch_stall  in  1  hold the current fetch output
instruction_out  out  DATA_W  fetched word
instr_valid  out  1  instruction_out is valid
fetch_fault  out  1  the current valid word is a faulted fetch
fault_code  out  2  00 none, 01 misaligned, 10 out of range
prog_mode  in  1  request program-load mode
prog_we  in  1  write strobe for the load port
prog_addr  in  $clog2(DEPTH)  word index for the load write
prog_data  in  DATA_W  word to write
prog_count  out  $clog2(DEPTH)+1  accepted writes since PROG was entered
prog_err  out  1  sticky flag: out-of-range write dropped in PROG
ready  out  1  high when state==RUN

Behaviour:
- State register: CLEAR, RUN, PROG. IDX_W = $clog2(DEPTH).
- Reset (reset=0, asynchronous) sets:
  - state=CLEAR, clr_idx=0
  - instruction_out=NOP_WORD, instr_valid=0, fetch_fault=0, fault_code=00
  - prog_count=0, prog_err=0, ready=0
- Memory contents are not reset directly; the CLEAR state overwrites them.
- CLEAR:
  - Writes NOP_WORD to mem[clr_idx] each cycle, then clr_idx++.
  - After the write to index DEPTH-1, moves to RUN. CLEAR lasts exactly DEPTH cycles.
  - prog_mode, fetch_req and prog_we are ignored.
- RUN:
  - If prog_mode=1: go to PROG next cycle; no fetch is accepted that cycle; instr_valid is cleared.
  - Else if fetch_stall=1: hold instruction_out, instr_valid, fetch_fault and fault_code unchanged.
  - Else if fetch_req=1: the fetch is registered and completes with 1-cycle latency. Next cycle instr_valid=1 and:
    - pc[0]=1: instruction_out=NOP_WORD, fetch_fault=1, fault_code=01
    - pc[ADDR_W-1:1] ≥ DEPTH: NOP_WORD, fetch_fault=1, fault_code=10
    - if both apply, misaligned (01) takes priority
    - otherwise: mem[pc[IDX_W:1]], fetch_fault=0, fault_code=00
  - Else: instr_valid=0 next cycle; instruction_out holds its last value.
- PROG:
  - On entry: prog_count=0, prog_err=0; instr_valid=0 and fetch_fault=0 throughout.
  - prog_we=1 with prog_addr<DEPTH: mem[prog_addr]=prog_data at the clock edge; prog_count++, saturating at DEPTH.
  - prog_we=1 with prog_addr≥DEPTH (possible only when DEPTH is not a power of two): write dropped; prog_err=1 (sticky until the next PROG entry or reset).
  - prog_mode=0: go to RUN next cycle. A prog_we in that same cycle is still honoured.
  - prog_count and prog_err hold their values after PROG exits.
- Read-after-load: a word written in the last PROG cycle is visible to the first RUN fetch.
- Reset mid-CLEAR or mid-PROG aborts the sequence and restarts CLEAR from index 0. The partially loaded program is lost.
- fetch_stall outside RUN has no effect.

Decomposition:
- Package instr_mem_pkg:
  - state enum {CLEAR, RUN, PROG}
  - fault_code constants FLT_NONE=2'b00, FLT_MISALIGN=2'b01, FLT_RANGE=2'b10
  - default NOP_WORD
- One sub-module, instr_mem_array: single write port, registered read port, DEPTH×DATA_W storage. It arbitrates the clear write vs. the load write by state.
- The FSM, fault checks and counters stay in instr_mem_ctrl.

Test Plan:
1. Release reset with DEPTH=16. Expect ready=0 for exactly 16 cycles, then ready=1. Fetch pc=0x0006 → instr_valid=1 one cycle later, instruction_out=16'h0000, fault_code=00.
2. PROG: write idx1=16'h3441, idx2=16'h2008, idx3=16'h0C82 on consecutive cycles; deassert prog_mode. Expect prog_count=3, prog_err=0. Fetch pc=0x0002, 0x0004, 0x0006 back-to-back → 16'h3441, 16'h2008, 16'h0C82 on consecutive cycles.
3. Fetch pc=0x0003 → instruction_out=16'h0000, fetch_fault=1, fault_code=01. Fetch pc=0x0040 → 16'h0000, fault_code=10.
4. Fetch pc=0x0002 (returns 16'h3441), then fetch_stall=1 for 3 cycles while pc=0x0004 → output held at 16'h3441, valid=1. Release stall → 16'h2008 next cycle.
5. In PROG, write 2 words, then assert reset=0 for one cycle mid-load → ready=0 and the CLEAR sequence reruns. Afterwards, fetch idx1 → 16'h0000, prog_count=0.
6. DEPTH=12: in PROG write prog_addr=13 → prog_err=1, prog_count unchanged. Then write prog_addr=11=16'hC004 and return to RUN. Fetch pc=0x0016 → 16'hC004.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory controller.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    PROG  = 2'd2
  } state_t;

  localparam logic [1:0]  FLT_NONE     = 2'b00;
  localparam logic [1:0]  FLT_MISALIGN = 2'b01;
  localparam logic [1:0]  FLT_RANGE    = 2'b10;

  localparam logic [15:0] NOP_WORD_DEF = 16'h0000;

  // Misalignment wins when a fetch is both odd and out of range.
  function automatic logic [1:0] fetch_fault_code(input logic misaligned,
                                                  input logic out_of_range);
    if (misaligned)        return FLT_MISALIGN;
    else if (out_of_range) return FLT_RANGE;
    else                   return FLT_NONE;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_W instruction storage: one write port shared by the clear
// sequencer and the program-load port, one registered read port.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int                 DATA_W   = 16,
  parameter int                 DEPTH    = 16,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic                         clk,
  input  state_t                       state,
  input  logic [$clog2(DEPTH)-1:0]     clr_idx,
  input  logic                         prog_we,
  input  logic [$clog2(DEPTH)-1:0]     prog_addr,
  input  logic [DATA_W-1:0]            prog_data,
  input  logic                         rd_en,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr,
  output logic [DATA_W-1:0]            rd_data
);

  localparam int               IDX_W   = $clog2(DEPTH);
  localparam logic [IDX_W:0]   DEPTH_L = (IDX_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en_p0;
  logic [IDX_W-1:0]  wr_addr_p0;
  logic [DATA_W-1:0] wr_data_p0;

  // Select the write source by controller state; loads past DEPTH are dropped.
  always_comb begin
    wr_en_p0   = 1'b0;
    wr_addr_p0 = clr_idx;
    wr_data_p0 = NOP_WORD;
    case (state)
      CLEAR: wr_en_p0 = 1'b1;
      PROG: begin
        wr_en_p0   = prog_we && ({1'b0, prog_addr} < DEPTH_L);
        wr_addr_p0 = prog_addr;
        wr_data_p0 = prog_data;
      end
      default: ;
    endcase
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (wr_en_p0) mem[wr_addr_p0] <= wr_data_p0;
  end

  // Registered read; holds its value when no read is issued.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: post-reset clear, runtime program load and
// a one-cycle registered fetch port with alignment/range fault reporting.
module instr_mem_ctrl
  import instr_mem_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          pc,
  input  logic                       fetch_req,
  input  logic                       fetch_stall,
  output logic [DATA_W-1:0]          instruction_out,
  output logic                       instr_valid,
  output logic                       fetch_fault,
  output logic [1:0]                 fault_code,
  input  logic                       prog_mode,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [DATA_W-1:0]          prog_data,
  output logic [$clog2(DEPTH):0]     prog_count,
  output logic                       prog_err,
  output logic                       ready
);

  localparam int                  IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W:0]      DEPTH_L  = (IDX_W+1)'(DEPTH);
  localparam logic [ADDR_W-2:0]   DEPTH_W  = (ADDR_W-1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH-1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  clr_idx;

  logic              misalign_p0;
  logic              range_p0;
  logic              fault_p0;
  logic              fetch_go_p0;
  logic              rd_en_p0;
  logic [DATA_W-1:0] rd_data_p1;
  logic              out_nop_p1;

  // ---- stage p0: fetch decode from the incoming PC ----
  assign misalign_p0 = pc[0];
  assign range_p0    = (pc[ADDR_W-1:1] >= DEPTH_W);
  assign fault_p0    = misalign_p0 | range_p0;
  assign fetch_go_p0 = (state == RUN) && !prog_mode && !fetch_stall && fetch_req;
  assign rd_en_p0    = fetch_go_p0 && !fault_p0;

  instr_mem_array #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP_WORD)
  ) u_array (
    .clk       (clk),
    .state     (state),
    .clr_idx   (clr_idx),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .rd_en     (rd_en_p0),
    .rd_addr   (pc[IDX_W:1]),
    .rd_data   (rd_data_p1)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= CLEAR;
    else        state <= state_nxt;
  end

  // Next-state logic: CLEAR runs once over every index, then RUN/PROG follow prog_mode.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_idx == LAST_IDX) state_nxt = RUN;
      RUN:     if (prog_mode)           state_nxt = PROG;
      PROG:    if (!prog_mode)          state_nxt = RUN;
      default:                          state_nxt = CLEAR;
    endcase
  end

  // Clear sequencer index, advanced once per CLEAR cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              clr_idx <= '0;
    else if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
  end

  // ---- stage p1: fetch result flags; a faulted fetch substitutes NOP_WORD ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fault_code  <= FLT_NONE;
      out_nop_p1  <= 1'b1;
    end else if (state == RUN) begin
      if (prog_mode) begin
        instr_valid <= 1'b0;
        fetch_fault <= 1'b0;
        fault_code  <= FLT_NONE;
      end else if (!fetch_stall) begin
        if (fetch_req) begin
          instr_valid <= 1'b1;
          fetch_fault <= fault_p0;
          fault_code  <= fetch_fault_code(misalign_p0, range_p0);
          out_nop_p1  <= fault_p0;
        end else begin
          instr_valid <= 1'b0;
        end
      end
    end
  end

  assign instruction_out = out_nop_p1 ? NOP_WORD : rd_data_p1;

  // Load bookkeeping: restart on PROG entry, count accepted writes, flag dropped ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prog_count <= '0;
      prog_err   <= 1'b0;
    end else if ((state == RUN) && prog_mode) begin
      prog_count <= '0;
      prog_err   <= 1'b0;
    end else if ((state == PROG) && prog_we) begin
      if ({1'b0, prog_addr} < DEPTH_L) begin
        if (prog_count < DEPTH_L) prog_count <= prog_count + 1'b1;
      end else begin
        prog_err <= 1'b1;
      end
    end
  end

  assign ready = (state == RUN);

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: a DEPTH=16 and a DEPTH=12 instance share all
// inputs and are each compared every cycle against a behavioural model.
module tb_instr_mem_ctrl;

  localparam logic [15:0] NOP = 16'h0000;
  localparam int M_CLEAR = 0, M_RUN = 1, M_PROG = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        fetch_req, fetch_stall, prog_mode, prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;

  logic [15:0] iout   [2];
  logic        ivld   [2];
  logic        iflt   [2];
  logic [1:0]  icode  [2];
  logic [4:0]  pcnt   [2];
  logic        perr_o [2];
  logic        rdy    [2];

  int checks = 0;
  int errors = 0;

  // Behavioural model, one slot per instance.
  int          m_mode [2];
  int          m_clr  [2];
  logic [15:0] m_mem  [2][16];
  logic [15:0] m_out  [2];
  bit          m_vld  [2];
  bit          m_flt  [2];
  int          m_code [2];
  int          m_cnt  [2];
  bit          m_err  [2];

  always #5 clk = ~clk;

  instr_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .NOP_WORD(16'h0000)) dut16 (
    .clk(clk), .reset(reset), .pc(pc), .fetch_req(fetch_req), .fetch_stall(fetch_stall),
    .instruction_out(iout[0]), .instr_valid(ivld[0]), .fetch_fault(iflt[0]),
    .fault_code(icode[0]), .prog_mode(prog_mode), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_count(pcnt[0]),
    .prog_err(perr_o[0]), .ready(rdy[0]));

  instr_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(12), .NOP_WORD(16'h0000)) dut12 (
    .clk(clk), .reset(reset), .pc(pc), .fetch_req(fetch_req), .fetch_stall(fetch_stall),
    .instruction_out(iout[1]), .instr_valid(ivld[1]), .fetch_fault(iflt[1]),
    .fault_code(icode[1]), .prog_mode(prog_mode), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_count(pcnt[1]),
    .prog_err(perr_o[1]), .ready(rdy[1]));

  function automatic int dep(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic string tg(input string s, input int k);
    return $sformatf("%s_d%0d", s, dep(k));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_CLEAR; m_clr[k] = 0; m_out[k] = NOP;
      m_vld[k] = 0; m_flt[k] = 0; m_code[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
    end
  endtask

  // Apply one rising edge worth of behaviour, using the inputs seen at that edge.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int d = dep(k);
      case (m_mode[k])
        M_CLEAR: begin
          m_mem[k][m_clr[k]] = NOP;
          m_clr[k]++;
          if (m_clr[k] == d) m_mode[k] = M_RUN;
        end
        M_RUN: begin
          if (prog_mode) begin
            m_mode[k] = M_PROG; m_vld[k] = 0; m_flt[k] = 0; m_code[k] = 0;
            m_cnt[k] = 0; m_err[k] = 0;
          end else if (fetch_stall) begin
            // everything holds
          end else if (fetch_req) begin
            int w = int'(pc) / 2;
            m_vld[k] = 1;
            if (pc % 2 == 1)  begin m_out[k] = NOP; m_flt[k] = 1; m_code[k] = 1; end
            else if (w >= d)  begin m_out[k] = NOP; m_flt[k] = 1; m_code[k] = 2; end
            else              begin m_out[k] = m_mem[k][w]; m_flt[k] = 0; m_code[k] = 0; end
          end else begin
            m_vld[k] = 0;
          end
        end
        default: begin
          if (prog_we) begin
            if (int'(prog_addr) < d) begin
              m_mem[k][prog_addr] = prog_data;
              if (m_cnt[k] < d) m_cnt[k]++;
            end else begin
              m_err[k] = 1;
            end
          end
          if (!prog_mode) m_mode[k] = M_RUN;
        end
      endcase
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk(tg("instruction_out", k), iout[k],   m_out[k]);
      chk(tg("instr_valid", k),     ivld[k],   m_vld[k]);
      chk(tg("fetch_fault", k),     iflt[k],   m_flt[k]);
      chk(tg("fault_code", k),      icode[k],  m_code[k]);
      chk(tg("prog_count", k),      pcnt[k],   m_cnt[k]);
      chk(tg("prog_err", k),        perr_o[k], m_err[k]);
      chk(tg("ready", k),           rdy[k],    (m_mode[k] == M_RUN));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    fetch_req = 0; fetch_stall = 0; prog_mode = 0; prog_we = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    model_reset();
    cycle();
    reset = 1;
  endtask

  task automatic wait_clear();
    int n16 = 0, n12 = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (rdy[1] && n12 == 0) n12 = i;
      if (rdy[0]) begin n16 = i; break; end
    end
    chk("clear_cycles_d16", n16, 16);
    chk("clear_cycles_d12", n12, 12);
  endtask

  task automatic fetch(input logic [15:0] a);
    idle(); fetch_req = 1; pc = a;
    cycle();
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d, input logic stay);
    fetch_req = 0; fetch_stall = 0; prog_mode = stay; prog_we = 1;
    prog_addr = a; prog_data = d;
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; pc = '0; prog_addr = '0; prog_data = '0;
    idle();
    #2;

    // Reset and the post-reset clear sequence.
    do_reset();
    chk("reset_ready", rdy[0], 0);
    chk("reset_out", iout[0], 16'h0000);
    wait_clear();

    // Fetch from freshly cleared memory.
    fetch(16'h0006);
    chk("t1_valid", ivld[0], 1);
    chk("t1_out", iout[0], 16'h0000);
    chk("t1_code", icode[0], 0);

    // Program three words, then read them back-to-back.
    idle(); prog_mode = 1; cycle();
    chk("t2_in_prog_ready", rdy[0], 0);
    load(4'd1, 16'h3441, 1);
    load(4'd2, 16'h2008, 1);
    load(4'd3, 16'h0C82, 1);
    idle(); cycle();
    chk("t2_count", pcnt[0], 3);
    chk("t2_err", perr_o[0], 0);
    fetch(16'h0002); chk("t2_rd1", iout[0], 16'h3441);
    fetch(16'h0004); chk("t2_rd2", iout[0], 16'h2008);
    fetch(16'h0006); chk("t2_rd3", iout[0], 16'h0C82);

    // Faulted fetches.
    fetch(16'h0003);
    chk("t3_mis_out", iout[0], 16'h0000);
    chk("t3_mis_flt", iflt[0], 1);
    chk("t3_mis_code", icode[0], 1);
    fetch(16'h0040);
    chk("t3_rng_out", iout[0], 16'h0000);
    chk("t3_rng_code", icode[0], 2);
    fetch(16'h0041);
    chk("t3_both_code", icode[0], 1);

    // Stall holds the output.
    fetch(16'h0002);
    chk("t4_pre", iout[0], 16'h3441);
    fetch_stall = 1; pc = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t4_hold_out", iout[0], 16'h3441);
      chk("t4_hold_vld", ivld[0], 1);
    end
    fetch_stall = 0; cycle();
    chk("t4_release", iout[0], 16'h2008);

    // Reset in the middle of a load.
    idle(); prog_mode = 1; cycle();
    load(4'd5, 16'hAAAA, 1);
    load(4'd6, 16'h5555, 1);
    prog_we = 0;
    do_reset();
    chk("t5_ready", rdy[0], 0);
    idle();
    wait_clear();
    fetch(16'h0002);
    chk("t5_out", iout[0], 16'h0000);
    chk("t5_count", pcnt[0], 0);

    // Out-of-range load on the 12-deep instance; last write honoured on exit.
    idle(); prog_mode = 1; cycle();
    load(4'd13, 16'h1234, 1);
    chk("t6_err_d12", perr_o[1], 1);
    chk("t6_cnt_d12", pcnt[1], 0);
    chk("t6_err_d16", perr_o[0], 0);
    load(4'd11, 16'hC004, 0);
    idle();
    fetch(16'h0016);
    chk("t6_rd_d12", iout[1], 16'hC004);
    chk("t6_cnt_after_d12", pcnt[1], 1);
    chk("t6_err_sticky_d12", perr_o[1], 1);

    // Count saturation.
    idle(); prog_mode = 1; cycle();
    for (int i = 0; i < 20; i++) load(4'(i), 16'(i * 16'h0111), 1);
    idle(); cycle();
    chk("sat_d16", pcnt[0], 16);
    chk("sat_d12", pcnt[1], 12);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle();
        do_reset();
        continue;
      end
      if ($urandom_range(0, 11) == 0) prog_mode = ~prog_mode;
      prog_we     = $urandom_range(0, 1) == 1;
      prog_addr   = 4'($urandom);
      prog_data   = 16'($urandom);
      fetch_req   = $urandom_range(0, 3) != 0;
      fetch_stall = $urandom_range(0, 4) == 0;
      pc          = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
